inst_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the IF stage (PCF) and instruction memory; it replaces the direct instruction-RAM read feeding the ID segment register. A hit returns the word one cycle after the request, like the synchronous instruction RAM. A miss raises `miss`, which drives the hazard unit's `ICacheMiss` input and stalls the pipeline. The refill FSM then fetches the whole line from memory in word beats.

---
 rtl/inst_cache.sv | 138 +++++++++++++
 tb/tb_inst_cache.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache
// Purpose  : Direct-mapped read-only instruction cache with a line-refill FSM
//            between the IF stage and instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module inst_cache #(
    parameter int LINE_ADDR_LEN = 2,
    parameter int SET_ADDR_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [31:0] addr,
    output logic [31:0] rd_data,
    output logic        miss,
    input  logic        flush,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN;
    localparam int SET_SIZE     = 1 << SET_ADDR_LEN;
    localparam int SET_LSB      = LINE_ADDR_LEN + 2;
    localparam int TAG_LSB      = LINE_ADDR_LEN + SET_ADDR_LEN + 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                    r_state;
    logic [SET_SIZE-1:0]       r_valid;
    logic [TAG_ADDR_LEN-1:0]   r_tags     [SET_SIZE];
    logic [31:0]               r_lineData [SET_SIZE][LINE_SIZE];
    logic [LINE_ADDR_LEN-1:0]  r_beatCnt;
    logic                      r_flushPending;
    logic [31:0]               r_rdData;
    logic                      r_memRdReq;
    logic [31:0]               r_memRdAddr;
    logic [31:0]               r_hitCount;
    logic [31:0]               r_missCount;

    logic [LINE_ADDR_LEN-1:0]  w_offset;
    logic [SET_ADDR_LEN-1:0]   w_set;
    logic [TAG_ADDR_LEN-1:0]   w_tag;
    logic [SET_ADDR_LEN-1:0]   w_refillSet;
    logic [TAG_ADDR_LEN-1:0]   w_refillTag;
    logic                      w_hit;
    logic                      w_lastBeat;
    logic                      w_unused;

    assign w_offset    = addr[SET_LSB-1:2];
    assign w_set       = addr[TAG_LSB-1:SET_LSB];
    assign w_tag       = addr[31:TAG_LSB];
    assign w_refillSet = r_memRdAddr[TAG_LSB-1:SET_LSB];
    assign w_refillTag = r_memRdAddr[31:TAG_LSB];
    assign w_unused    = &{1'b0, addr[1:0]};

    assign w_hit      = r_valid[w_set] && (r_tags[w_set] == w_tag);
    assign w_lastBeat = (r_beatCnt == {LINE_ADDR_LEN{1'b1}});

    assign miss        = rd_req && ((r_state != IDLE) || !w_hit);
    assign rd_data     = r_rdData;
    assign mem_rd_req  = r_memRdReq;
    assign mem_rd_addr = r_memRdAddr;
    assign hit_count   = r_hitCount;
    assign miss_count  = r_missCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_valid        <= '0;
            r_beatCnt      <= '0;
            r_flushPending <= 1'b0;
            r_rdData       <= '0;
            r_memRdReq     <= 1'b0;
            r_memRdAddr    <= '0;
            r_hitCount     <= '0;
            r_missCount    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_req && w_hit) begin
                        r_rdData   <= r_lineData[w_set][w_offset];
                        r_hitCount <= r_hitCount + 32'd1;
                    end else if (rd_req) begin
                        r_state     <= REFILL;
                        r_memRdReq  <= 1'b1;
                        r_memRdAddr <= {addr[31:SET_LSB], {SET_LSB{1'b0}}};
                        r_beatCnt   <= '0;
                        r_missCount <= r_missCount + 32'd1;
                    end
                    // Lookup above sees the pre-flush valid bits.
                    if (flush) begin
                        r_valid <= '0;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        r_flushPending <= 1'b1;
                    end
                    if (mem_rd_valid) begin
                        r_beatCnt <= r_beatCnt + 1'b1;
                        if (w_lastBeat) begin
                            r_state        <= IDLE;
                            r_memRdReq     <= 1'b0;
                            r_flushPending <= 1'b0;
                            // A flush seen anywhere during the burst discards the line.
                            if (r_flushPending || flush) begin
                                r_valid <= '0;
                            end else begin
                                r_valid[w_refillSet] <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == REFILL && mem_rd_valid) begin
            r_lineData[w_refillSet][r_beatCnt] <= mem_rd_data;
            if (w_lastBeat) begin
                r_tags[w_refillSet] <= w_refillTag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_cache
// Purpose  : Self-checking bench for inst_cache: directed vectors, hand-written
//            flush/reset sequences and a randomized run against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [31:0] addr;
    logic [31:0] rd_data;
    logic        miss;
    logic        flush;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int passCnt  = 0;
    int totalCnt = 0;

    inst_cache dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req       (rd_req),
        .addr         (addr),
        .rd_data      (rd_data),
        .miss         (miss),
        .flush        (flush),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdReq;
        logic [31:0] addr;
        logic        flush;
        logic        memValid;
        logic [31:0] memData;
        logic        eMiss;
        logic        eMemReq;
        logic [31:0] eMemAddr;
        logic [31:0] eData;
        logic [31:0] eHits;
        logic [31:0] eMisses;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rq, input logic [31:0] a, input logic fl,
                                input logic mv, input logic [31:0] md,
                                input logic em, input logic emr, input logic [31:0] ema,
                                input logic [31:0] ed, input logic [31:0] eh,
                                input logic [31:0] emc);
        vec_t v;
        v.rdReq = rq;  v.addr = a;     v.flush = fl;   v.memValid = mv; v.memData = md;
        v.eMiss = em;  v.eMemReq = emr; v.eMemAddr = ema;
        v.eData = ed;  v.eHits = eh;   v.eMisses = emc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic drive(input logic rq, input logic [31:0] a, input logic fl,
                         input logic mv, input logic [31:0] md);
        rd_req = rq; addr = a; flush = fl; mem_rd_valid = mv; mem_rd_data = md;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Reference model state: which line address each set holds.
    bit          mRefill;
    bit          mPend;
    logic [31:0] mRefAddr;
    int          mBeats;
    bit          mResValid [16];
    logic [31:0] mResLine  [16];
    logic [31:0] mLast;
    logic [31:0] mHits;
    logic [31:0] mMisses;

    function automatic bit resident(input logic [31:0] a);
        return mResValid[a[7:4]] && (mResLine[a[7:4]] == (a & ~32'hF));
    endfunction

    task automatic clearModel();
        for (int k = 0; k < 16; k++) mResValid[k] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("reset.rd_data",     rd_data,           32'h0);
        chk("reset.mem_rd_req",  32'(mem_rd_req),   32'h0);
        chk("reset.mem_rd_addr", mem_rd_addr,       32'h0);
        chk("reset.hit_count",   hit_count,         32'h0);
        chk("reset.miss_count",  miss_count,        32'h0);
        chk("reset.miss",        32'(miss),         32'h0);
        rst = 1'b1;
        step();

        // ---------------- directed vector table ----------------
        vecs.push_back(mk(1, 32'h0, 0, 0, 0,         1, 0, 32'h0, 32'h0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 32'h0, 0, 1, 32'hA0 + i, 1, 1, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0,         0, 0, 32'h0, 32'h0, 0, 1));
        vecs.push_back(mk(1, 32'h8, 0, 0, 0,         0, 0, 32'h0, 32'hA0, 1, 1));
        vecs.push_back(mk(0, 32'h8, 0, 0, 0,         0, 0, 32'h0, 32'hA2, 2, 1));
        vecs.push_back(mk(1, 32'h100, 0, 0, 0,       1, 0, 32'h0, 32'hA2, 2, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 32'h100, 0, 1, 32'hB0 + i, 1, 1, 32'h100, 32'hA2, 2, 2));
        vecs.push_back(mk(1, 32'h104, 0, 0, 0,       0, 0, 32'h100, 32'hA2, 2, 2));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0,         1, 0, 32'h100, 32'hB1, 3, 2));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 32'h0, 0, 1, 32'hC0 + i, 1, 1, 32'h0, 32'hB1, 3, 3));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0,         0, 0, 32'h0, 32'hB1, 3, 3));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0,         0, 0, 32'h0, 32'hC0, 4, 3));
        vecs.push_back(mk(1, 32'hC, 0, 0, 0,         1, 0, 32'h0, 32'hC0, 4, 3));
        vecs.push_back(mk(1, 32'hC, 0, 0, 0,         1, 1, 32'h0, 32'hC0, 4, 4));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1, 32'hC, 0, 0, 0,     1, 1, 32'h0, 32'hC0, 4, 4));
            vecs.push_back(mk(1, 32'hC, 0, 1, 32'h11 + i, 1, 1, 32'h0, 32'hC0, 4, 4));
            if (i < 3) vecs.push_back(mk(1, 32'hC, 0, 0, 0, 1, 1, 32'h0, 32'hC0, 4, 4));
        end
        vecs.push_back(mk(1, 32'hC, 0, 0, 0,         0, 0, 32'h0, 32'hC0, 4, 4));
        vecs.push_back(mk(0, 32'hC, 0, 1, 32'hDEAD,  0, 0, 32'h0, 32'h14, 5, 4));
        vecs.push_back(mk(1, 32'h0, 0, 0, 0,         0, 0, 32'h0, 32'h14, 5, 4));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0,         0, 0, 32'h0, 32'h11, 6, 4));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdReq, vecs[i].addr, vecs[i].flush, vecs[i].memValid, vecs[i].memData);
            chk($sformatf("v%0d.miss", i),        32'(miss),       32'(vecs[i].eMiss));
            chk($sformatf("v%0d.mem_rd_req", i),  32'(mem_rd_req), 32'(vecs[i].eMemReq));
            chk($sformatf("v%0d.mem_rd_addr", i), mem_rd_addr,     vecs[i].eMemAddr);
            chk($sformatf("v%0d.rd_data", i),     rd_data,         vecs[i].eData);
            chk($sformatf("v%0d.hit_count", i),   hit_count,       vecs[i].eHits);
            chk($sformatf("v%0d.miss_count", i),  miss_count,      vecs[i].eMisses);
            step();
        end

        // ---------------- flush during the 2nd beat ----------------
        drive(1, 32'h40, 0, 0, 0);
        chk("fl.first_miss", 32'(miss), 32'h1);
        step();
        drive(1, 32'h40, 0, 1, 32'hD0);
        chk("fl.mem_rd_addr", mem_rd_addr, 32'h40);
        step();
        drive(1, 32'h40, 1, 1, 32'hD1); step();
        drive(1, 32'h40, 0, 1, 32'hD2); step();
        drive(1, 32'h40, 0, 1, 32'hD3); step();
        drive(1, 32'h40, 0, 0, 0);
        chk("fl.remiss",     32'(miss),       32'h1);
        chk("fl.req_low",    32'(mem_rd_req), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h40, 0, 1, 32'hE0 + i);
            chk($sformatf("fl.beat%0d.req", i), 32'(mem_rd_req), 32'h1);
            step();
        end
        drive(1, 32'h40, 0, 0, 0);
        chk("fl.hit",        32'(miss),  32'h0);
        chk("fl.miss_count", miss_count, 32'h6);
        step();
        drive(1, 32'h0, 0, 0, 0);
        chk("fl.rd_data",    rd_data,    32'hE0);
        chk("fl.set0_gone",  32'(miss),  32'h1);
        step();

        // ---------------- reset during the 3rd beat ----------------
        drive(1, 32'h0, 0, 1, 32'hF0); step();
        drive(1, 32'h0, 0, 1, 32'hF1); step();
        drive(1, 32'h0, 0, 1, 32'hF2);
        rst = 1'b0;
        #1;
        chk("rs.req_drop",   32'(mem_rd_req), 32'h0);
        chk("rs.addr_clr",   mem_rd_addr,     32'h0);
        chk("rs.miss_cnt",   miss_count,      32'h0);
        chk("rs.rd_data",    rd_data,         32'h0);
        step();
        rst = 1'b1;
        drive(1, 32'h0, 0, 0, 0);
        chk("rs.remiss",     32'(miss), 32'h1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h0, 0, 1, 32'h60 + i);
            chk($sformatf("rs.beat%0d.addr", i), mem_rd_addr, 32'h0);
            step();
        end
        drive(1, 32'h8, 0, 0, 0);
        chk("rs.hit", 32'(miss), 32'h0);
        step();
        drive(0, 32'h0, 0, 0, 0);
        chk("rs.word2",      rd_data,    32'h62);
        chk("rs.hit_count",  hit_count,  32'h1);
        chk("rs.miss_count", miss_count, 32'h1);

        // ---------------- randomized run vs. memory model ----------------
        rst = 1'b0;
        step();
        rst = 1'b1;
        clearModel();
        mRefill = 0; mPend = 0; mRefAddr = 0; mBeats = 0;
        mLast = 0; mHits = 0; mMisses = 0;
        for (int c = 0; c < 1500; c++) begin
            logic        rq, fl, mv, expMiss;
            logic [31:0] a, md;
            rq = ($urandom_range(0, 9) < 8);
            a  = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            fl = ($urandom_range(0, 39) == 0);
            if (mRefill) begin
                mv = ($urandom_range(0, 2) != 0);
                md = mv ? memWord(mRefAddr + 32'(4 * mBeats)) : 32'h0;
            end else begin
                mv = ($urandom_range(0, 9) == 0);
                md = mv ? $urandom : 32'h0;
            end
            drive(rq, a, fl, mv, md);
            expMiss = rq && (mRefill || !resident(a));
            chk($sformatf("r%0d.miss", c),       32'(miss),       32'(expMiss));
            chk($sformatf("r%0d.mem_rd_req", c), 32'(mem_rd_req), 32'(mRefill));
            if (mRefill)
                chk($sformatf("r%0d.mem_rd_addr", c), mem_rd_addr, mRefAddr);
            chk($sformatf("r%0d.rd_data", c), rd_data, mLast);
            if (c % 64 == 0) begin
                chk($sformatf("r%0d.hit_count", c),  hit_count,  mHits);
                chk($sformatf("r%0d.miss_count", c), miss_count, mMisses);
            end
            if (!mRefill) begin
                if (rq) begin
                    if (resident(a)) begin
                        mLast = memWord(a);
                        mHits++;
                    end else begin
                        mRefill = 1; mRefAddr = a & ~32'hF; mBeats = 0; mMisses++;
                    end
                end
                if (fl) clearModel();
            end else begin
                if (fl) mPend = 1;
                if (mv) begin
                    mBeats++;
                    if (mBeats == 4) begin
                        mRefill = 0;
                        if (mPend) clearModel();
                        else begin
                            mResValid[mRefAddr[7:4]] = 1'b1;
                            mResLine[mRefAddr[7:4]]  = mRefAddr;
                        end
                        mPend = 0;
                    end
                end
            end
            step();
        end
        drive(0, 32'h0, 0, 0, 0);
        chk("rand.hit_count",  hit_count,  mHits);
        chk("rand.miss_count", miss_count, mMisses);
        chk("rand.rd_data",    rd_data,    mLast);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
`default_nettype wire
